ram_2host_arb: RTL and testbench

- Shares the single-port 32-bit data RAM (1-cycle read/write latency, byte enables) between two Ibex-style hosts: instruction fetch (host I) and load/store (host D).
- Per cycle it grants at most one request, forwards it to the RAM, and routes the response back to the owning host one cycle later.
- Fixed priority D > I, with a starvation limiter so host I always makes progress.
- Requests outside the RAM window get an error response and never reach the RAM.

---
 rtl/ram_2host_arb_pkg.sv | 25 ++
 rtl/ram_2host_arb_if.sv | 43 ++++
 rtl/ram_2host_arb_chk.sv | 35 +++
 rtl/ram_2host_arb_sel.sv | 52 +++++
 rtl/ram_2host_arb.sv | 108 ++++++++++
 tb/tb_ram_2host_arb.sv | 170 +++++++++++++++++
 6 files changed

// File: rtl/ram_2host_arb_pkg.sv
// Shared types for the two-host RAM arbiter: host identifiers, response tag and
// the address-window helper.
package ram_arb_pkg;

  localparam int unsigned StarveW = 4;

  typedef enum logic [1:0] {
    HostNone = 2'd0,
    HostI    = 2'd1,
    HostD    = 2'd2
  } host_e;

  typedef struct packed {
    host_e owner;
    logic  err;
  } resp_tag_t;

  // Offset compare avoids overflow when the window ends at the top of the map.
  function automatic logic addr_in_window(input logic [31:0] addr,
                                          input logic [31:0] base,
                                          input logic [31:0] bytes);
    return (addr >= base) && ((addr - base) < bytes);
  endfunction

endpackage

// File: rtl/ram_2host_arb_if.sv
// Bus bundle between the two hosts, the arbiter and the single-port RAM.
interface ram_2host_arb_if;
  logic        i_req_i;
  logic        i_gnt_o;
  logic [31:0] i_addr_i;
  logic        i_rvalid_o;
  logic [31:0] i_rdata_o;
  logic        i_err_o;

  logic        d_req_i;
  logic        d_gnt_o;
  logic [31:0] d_addr_i;
  logic        d_we_i;
  logic [3:0]  d_be_i;
  logic [31:0] d_wdata_i;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic        d_err_o;

  logic        ram_req_o;
  logic        ram_we_o;
  logic [3:0]  ram_be_o;
  logic [31:0] ram_addr_o;
  logic [31:0] ram_wdata_o;
  logic        ram_rvalid_i;
  logic [31:0] ram_rdata_i;

  modport slave (
    input  i_req_i, i_addr_i, d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
           ram_rvalid_i, ram_rdata_i,
    output i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
           ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );

  modport master (
    output i_req_i, i_addr_i, d_req_i, d_addr_i, d_we_i, d_be_i, d_wdata_i,
           ram_rvalid_i, ram_rdata_i,
    input  i_gnt_o, i_rvalid_o, i_rdata_o, i_err_o,
           d_gnt_o, d_rvalid_o, d_rdata_o, d_err_o,
           ram_req_o, ram_we_o, ram_be_o, ram_addr_o, ram_wdata_o
  );
endinterface

// File: rtl/ram_2host_arb_chk.sv
// Protocol checks for the arbiter: one-hot grant, response causality and
// agreement between the RAM response and the tracked owner.
module ram_2host_arb_chk
  import ram_arb_pkg::*;
(
  input logic      clk_i,
  input logic      rst_ni,
  input logic      i_gnt,
  input logic      d_gnt,
  input logic      i_rvalid,
  input logic      d_rvalid,
  input logic      ram_rvalid,
  input resp_tag_t resp_tag
);

  logic rst_q_r;
  logic any_gnt_q_r;

  // Remember last cycle's reset and grant state
  always_ff @(posedge clk_i) begin
    rst_q_r     <= rst_ni;
    any_gnt_q_r <= i_gnt | d_gnt;
  end

  a_gnt_onehot : assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(i_gnt && d_gnt));

  a_rvalid_after_gnt : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (i_rvalid || d_rvalid) |-> any_gnt_q_r);

  // A RAM response straddling reset release is legitimately orphaned.
  a_ram_rvalid_match : assert property (@(posedge clk_i) disable iff (!rst_ni || !rst_q_r)
    ram_rvalid == ((resp_tag.owner != HostNone) && !resp_tag.err));

endmodule

// File: rtl/ram_2host_arb_sel.sv
// Winner selection: D has priority, I is forced through after MaxStarve
// consecutive losing cycles.
module ram_arb_sel
  import ram_arb_pkg::*;
#(
  parameter int unsigned MaxStarve = 4
) (
  input  logic  clk_i,
  input  logic  rst_ni,
  input  logic  i_req,
  input  logic  d_req,
  output host_e winner,
  output logic  i_gnt,
  output logic  d_gnt
);

  logic [StarveW-1:0] starve_cnt_r;
  logic               force_i_s;

  // Pick the winner for this cycle; nobody wins while reset is held
  always_comb begin
    winner    = HostNone;
    force_i_s = (starve_cnt_r == StarveW'(MaxStarve));
    if (!rst_ni) begin
      winner = HostNone;
    end else if (i_req && (!d_req || force_i_s)) begin
      winner = HostI;
    end else if (d_req) begin
      winner = HostD;
    end else begin
      winner = HostNone;
    end
    i_gnt = (winner == HostI);
    d_gnt = (winner == HostD);
  end

  // Count consecutive cycles host I waits, saturating at the limit
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      starve_cnt_r <= {StarveW{1'b0}};
    end else if (i_req && !i_gnt) begin
      if (!force_i_s) begin
        starve_cnt_r <= starve_cnt_r + StarveW'(1);
      end else begin
        starve_cnt_r <= starve_cnt_r;
      end
    end else begin
      starve_cnt_r <= {StarveW{1'b0}};
    end
  end

endmodule

// File: rtl/ram_2host_arb.sv
// Two-host arbiter in front of a single-port 1-cycle RAM: window decode, RAM
// port muxing and routing of the response back to the granted host.
module ram_2host_arb
  import ram_arb_pkg::*;
#(
  parameter int unsigned MemDepth  = 128,
  parameter logic [31:0] BaseAddr  = 32'h0000_0000,
  parameter int unsigned MaxStarve = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  ram_2host_arb_if.slave bus
);

  localparam logic [31:0] MemBytes = 32'(MemDepth * 4);

  host_e       winner_s;
  logic        i_gnt_s, d_gnt_s;
  logic [31:0] win_addr_s;
  logic        in_range_s;
  logic        ram_req_s, ram_we_s;
  logic [3:0]  ram_be_s;
  logic [31:0] ram_addr_s, ram_wdata_s;
  resp_tag_t   resp_r;
  logic        i_own_s, d_own_s;

  ram_arb_sel #(.MaxStarve(MaxStarve)) u_sel (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .i_req  (bus.i_req_i),
    .d_req  (bus.d_req_i),
    .winner (winner_s),
    .i_gnt  (i_gnt_s),
    .d_gnt  (d_gnt_s)
  );

  // Decode the winner's address and steer its fields onto the RAM port
  always_comb begin
    ram_req_s   = 1'b0;
    ram_we_s    = 1'b0;
    ram_be_s    = 4'h0;
    ram_addr_s  = 32'h0;
    ram_wdata_s = 32'h0;
    case (winner_s)
      HostI:   win_addr_s = bus.i_addr_i;
      HostD:   win_addr_s = bus.d_addr_i;
      default: win_addr_s = 32'h0;
    endcase
    in_range_s = addr_in_window(win_addr_s, BaseAddr, MemBytes);
    if ((winner_s != HostNone) && in_range_s) begin
      ram_req_s  = 1'b1;
      ram_addr_s = win_addr_s - BaseAddr;
      if (winner_s == HostD) begin
        ram_we_s    = bus.d_we_i;
        ram_be_s    = bus.d_be_i;
        ram_wdata_s = bus.d_wdata_i;
      end else begin
        ram_we_s    = 1'b0;
        ram_be_s    = 4'hF;
        ram_wdata_s = 32'h0;
      end
    end else begin
      ram_req_s = 1'b0;
    end
  end

  // Track who owns next cycle's response and whether it is an error
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      resp_r <= '{owner: HostNone, err: 1'b0};
    end else if (winner_s != HostNone) begin
      resp_r <= '{owner: winner_s, err: !in_range_s};
    end else begin
      resp_r <= '{owner: HostNone, err: 1'b0};
    end
  end

  // A response still pending when reset asserts is dropped immediately.
  assign i_own_s = rst_ni && (resp_r.owner == HostI);
  assign d_own_s = rst_ni && (resp_r.owner == HostD);

  assign bus.i_gnt_o     = i_gnt_s;
  assign bus.d_gnt_o     = d_gnt_s;
  assign bus.ram_req_o   = ram_req_s;
  assign bus.ram_we_o    = ram_we_s;
  assign bus.ram_be_o    = ram_be_s;
  assign bus.ram_addr_o  = ram_addr_s;
  assign bus.ram_wdata_o = ram_wdata_s;

  assign bus.i_rvalid_o = i_own_s;
  assign bus.i_err_o    = i_own_s && resp_r.err;
  assign bus.i_rdata_o  = (i_own_s && !resp_r.err) ? bus.ram_rdata_i : 32'h0;
  assign bus.d_rvalid_o = d_own_s;
  assign bus.d_err_o    = d_own_s && resp_r.err;
  assign bus.d_rdata_o  = (d_own_s && !resp_r.err) ? bus.ram_rdata_i : 32'h0;

  ram_2host_arb_chk u_chk (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .i_gnt      (i_gnt_s),
    .d_gnt      (d_gnt_s),
    .i_rvalid   (bus.i_rvalid_o),
    .d_rvalid   (bus.d_rvalid_o),
    .ram_rvalid (bus.ram_rvalid_i),
    .resp_tag   (resp_r)
  );

endmodule

// File: tb/tb_ram_2host_arb.sv
// Directed bench for ram_2host_arb with a behavioural 1-cycle RAM model.
module tb_ram_2host_arb;

  logic clk_i  = 1'b0;
  logic rst_ni = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] mem [128];
  bit          mem_init = 1'b0;

  ram_2host_arb_if bus ();

  ram_2host_arb dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  // RAM model: 1-cycle latency, byte-enable writes, fixed preload on first edge
  always @(posedge clk_i) begin
    if (!mem_init) begin
      for (int k = 0; k < 128; k++) mem[k] <= 32'h0;
      mem[0]   <= 32'h1000_0000;
      mem[1]   <= 32'h1000_0004;
      mem[2]   <= 32'h1000_0008;
      mem[8]   <= 32'hCAFE_0008;
      mem[16]  <= 32'h0D0D_0010;
      mem[127] <= 32'h7F7F_007F;
      mem_init <= 1'b1;
    end
    bus.ram_rvalid_i <= bus.ram_req_o;
    if (bus.ram_req_o) begin
      if (bus.ram_we_o) begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_be_o[b]) mem[bus.ram_addr_o[8:2]][8*b +: 8] <= bus.ram_wdata_o[8*b +: 8];
      end
      bus.ram_rdata_i <= mem[bus.ram_addr_o[8:2]];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bits: [6]=i_gnt [5]=d_gnt [4]=i_rvalid [3]=d_rvalid [2]=i_err [1]=d_err [0]=ram_req
  function automatic logic [31:0] flags();
    return {25'h0, bus.i_gnt_o, bus.d_gnt_o, bus.i_rvalid_o, bus.d_rvalid_o,
            bus.i_err_o, bus.d_err_o, bus.ram_req_o};
  endfunction

  task automatic cycle(input logic rst, input logic ir, input logic [31:0] ia,
                       input logic dr, input logic dwe, input logic [3:0] dbe,
                       input logic [31:0] da, input logic [31:0] dwd);
    @(posedge clk_i);
    #1;
    rst_ni        = rst;
    bus.i_req_i   = ir;
    bus.i_addr_i  = ia;
    bus.d_req_i   = dr;
    bus.d_we_i    = dwe;
    bus.d_be_i    = dbe;
    bus.d_addr_i  = da;
    bus.d_wdata_i = dwd;
    #1;
  endtask

  logic [11:0] i_win;
  logic [1:0]  prev_rv;
  logic        exp_i;

  initial begin
    bus.i_req_i = 1'b0; bus.i_addr_i = 32'h0; bus.d_req_i = 1'b0; bus.d_we_i = 1'b0;
    bus.d_be_i = 4'h0; bus.d_addr_i = 32'h0; bus.d_wdata_i = 32'h0;

    // Requests during reset get no grant
    for (int k = 0; k < 3; k++) begin
      cycle(1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 4'hF, 32'h4, 32'h0);
      check_eq("rst_flags", flags(), 32'h0);
    end
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check_eq("idle_flags", flags(), 32'h0);
    end

    // Partial write then read back
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 4'h3, 32'h10, 32'hDEAD_BEEF);
    check_eq("wr_flags", flags(), 32'h21);
    check_eq("wr_addr", bus.ram_addr_o, 32'h10);
    check_eq("wr_we", {31'h0, bus.ram_we_o}, 32'h1);
    check_eq("wr_be", {28'h0, bus.ram_be_o}, 32'h3);
    check_eq("wr_wdata", bus.ram_wdata_o, 32'hDEAD_BEEF);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    check_eq("rd_flags", flags(), 32'h29);
    check_eq("rd_addr", bus.ram_addr_o, 32'h10);
    check_eq("rd_we", {31'h0, bus.ram_we_o}, 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("rd_resp_flags", flags(), 32'h08);
    check_eq("rd_rdata", bus.d_rdata_o, 32'h0000_BEEF);

    // Contention: I forced through every fifth cycle
    i_win   = 12'h210;
    prev_rv = 2'b00;
    for (int k = 0; k < 12; k++) begin
      cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      exp_i = i_win[k];
      check_eq("arb_gnt", {30'h0, bus.i_gnt_o, bus.d_gnt_o}, {30'h0, exp_i, !exp_i});
      check_eq("arb_addr", bus.ram_addr_o, exp_i ? 32'h20 : 32'h40);
      check_eq("arb_rvalid", {30'h0, bus.i_rvalid_o, bus.d_rvalid_o}, {30'h0, prev_rv});
      if (prev_rv[1]) check_eq("arb_i_rdata", bus.i_rdata_o, 32'hCAFE_0008);
      else if (prev_rv[0]) check_eq("arb_d_rdata", bus.d_rdata_o, 32'h0D0D_0010);
      else check_eq("arb_no_rdata", bus.i_rdata_o | bus.d_rdata_o, 32'h0);
      prev_rv = {exp_i, !exp_i};
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("arb_last_rvalid", {30'h0, bus.i_rvalid_o, bus.d_rvalid_o}, {30'h0, prev_rv});
    check_eq("arb_last_rdata", bus.d_rdata_o, 32'h0D0D_0010);

    // Window boundary: last word in range, next word out of range
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h1FC, 32'h0);
    check_eq("edge_flags", flags(), 32'h21);
    check_eq("edge_addr", bus.ram_addr_o, 32'h1FC);
    cycle(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0);
    check_eq("oor_flags", flags(), 32'h28);
    check_eq("oor_addr", bus.ram_addr_o, 32'h0);
    check_eq("oor_be", {28'h0, bus.ram_be_o}, 32'h0);
    check_eq("edge_rdata", bus.d_rdata_o, 32'h7F7F_007F);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("oor_resp_flags", flags(), 32'h0A);
    check_eq("oor_rdata", bus.d_rdata_o, 32'h0);

    // Back-to-back instruction fetches
    for (int k = 0; k < 4; k++) begin
      if (k < 3) cycle(1'b1, 1'b1, 32'(4 * k), 1'b0, 1'b1, 4'h3, 32'h0, 32'h0);
      else cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
      check_eq("if_flags", flags(), (k == 0) ? 32'h41 : (k == 3) ? 32'h10 : 32'h51);
      if (k < 3) begin
        check_eq("if_addr", bus.ram_addr_o, 32'(4 * k));
        check_eq("if_we_be", {27'h0, bus.ram_we_o, bus.ram_be_o}, 32'h0F);
      end
      if (k > 0) check_eq("if_rdata", bus.i_rdata_o, 32'h1000_0000 + 32'(4 * (k - 1)));
    end

    // Reset while a D response is pending
    cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    check_eq("mid_gnt_flags", flags(), 32'h21);
    cycle(1'b0, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h10, 32'h0);
    check_eq("mid_rst_flags", flags(), 32'h0);
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("mid_post_flags", flags(), 32'h0);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b1, 1'b1, 32'h20, 1'b1, 1'b0, 4'hF, 32'h40, 32'h0);
      check_eq("post_rst_gnt", {30'h0, bus.i_gnt_o, bus.d_gnt_o},
               (k == 4) ? 32'h2 : 32'h1);
    end
    cycle(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
    check_eq("post_rst_resp", flags(), 32'h10);
    check_eq("post_rst_rdata", bus.i_rdata_o, 32'hCAFE_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
